// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and helper functions for the fifo_flow buffer.
//   out_mode_e   - output stage selection (fall-through or registered)
//   count_width  - bits needed to hold an occupancy of 0..num
//   addr_width   - bits needed to address a storage array of 'depth' entries
//   ptr_inc      - pointer increment that wraps to 0 after depth-1
package fifo_pkg;

  typedef enum logic {
    MODE_FALL_THROUGH = 1'b0,
    MODE_REG_OUT      = 1'b1
  } out_mode_e;

  function automatic int unsigned count_width(input int unsigned num);
    return $clog2(num + 1);
  endfunction

  // A one-entry array still needs a one-bit address to keep ports legal.
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Wraps on the actual depth, so non-power-of-two depths are supported.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return ((ptr + 1) >= depth) ? 32'd0 : (ptr + 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: storage array for fifo_flow, no reset.
//   clk    - write clock
//   we     - write enable, wdata stored at waddr on the rising edge
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - asynchronous read data at raddr
module fifo_mem import fifo_pkg::*; #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = addr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Single synchronous write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Asynchronous read port.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_flow.sv
// fifo_flow: parametrised synchronous FIFO with ready/valid on both sides,
// occupancy count, almost-full flag, flush and selectable output stage.
//   clk            - clock, all state changes on the rising edge
//   rst            - synchronous active-high reset
//   IN_flush       - synchronous discard of all contents
//   IN_valid       - upstream offers IN_data
//   IN_data        - write data
//   OUT_ready      - FIFO can accept an entry (count != NUM)
//   OUT_valid      - OUT_data holds the oldest entry (count != 0)
//   OUT_data       - oldest entry
//   IN_ready       - downstream accepts OUT_data
//   OUT_count      - occupancy 0..NUM
//   OUT_almostFull - count >= AF_THRESH
module fifo_flow import fifo_pkg::*; #(
  parameter int unsigned NUM       = 128,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned AF_THRESH = NUM - 2,
  parameter int unsigned REG_OUT   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          IN_flush,
  input  logic                          IN_valid,
  input  logic [WIDTH-1:0]              IN_data,
  output logic                          OUT_ready,
  output logic                          OUT_valid,
  output logic [WIDTH-1:0]              OUT_data,
  input  logic                          IN_ready,
  output logic [count_width(NUM)-1:0]   OUT_count,
  output logic                          OUT_almostFull
);

  localparam out_mode_e   MODE     = (REG_OUT != 0) ? MODE_REG_OUT : MODE_FALL_THROUGH;
  localparam bit          REG_MODE = (MODE == MODE_REG_OUT);
  localparam int unsigned CW       = count_width(NUM);
  // The output register holds one of the NUM entries in registered mode.
  localparam int unsigned SDEPTH   = REG_MODE ? (NUM - 1) : NUM;
  localparam int unsigned PW       = addr_width(SDEPTH);

  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic             af_q, af_d;
  logic [WIDTH-1:0] dout_q, dout_d;

  logic             push_c;
  logic             pop_c;
  logic             direct_c;
  logic             mem_we_c;
  logic             mem_re_c;
  logic [WIDTH-1:0] mem_rdata;

  fifo_mem #(
    .DEPTH (SDEPTH),
    .WIDTH (WIDTH),
    .AW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we_c),
    .waddr (wptr_q),
    .wdata (IN_data),
    .raddr (rptr_q),
    .rdata (mem_rdata)
  );

  // Handshake decode; flags come from registered state only.
  always_comb begin
    push_c   = IN_valid & ready_q;
    pop_c    = valid_q & IN_ready;
    // Registered mode: data bound for an empty (or emptying) output stage skips storage.
    direct_c = REG_MODE && push_c &&
               ((count_q == '0) || ((count_q == CW'(1)) && pop_c));
    mem_we_c = push_c && !direct_c && !IN_flush;
    // Registered mode only reads storage when it holds something behind the output stage.
    mem_re_c = pop_c && (!REG_MODE || (count_q >= CW'(2)));
  end

  // Next-state for count, pointers, output stage and flags.
  always_comb begin
    count_d = count_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    dout_d  = dout_q;

    if (IN_flush) begin
      count_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
    end else begin
      if (push_c && !pop_c) begin
        count_d = count_q + CW'(1);
      end else if (!push_c && pop_c) begin
        count_d = count_q - CW'(1);
      end

      if (mem_we_c) begin
        wptr_d = PW'(ptr_inc(32'(wptr_q), SDEPTH));
      end
      if (mem_re_c) begin
        rptr_d = PW'(ptr_inc(32'(rptr_q), SDEPTH));
      end

      if (direct_c) begin
        dout_d = IN_data;
      end else if (mem_re_c) begin
        dout_d = mem_rdata;
      end
    end

    // Flags are registered copies of what the next count decodes to.
    ready_d = (count_d != CW'(NUM));
    valid_d = (count_d != '0);
    af_d    = (count_d >= CW'(AF_THRESH));
  end

  // State register; reset has priority over flush and handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      af_q    <= 1'b0;
      dout_q  <= '0;
    end else begin
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      af_q    <= af_d;
      dout_q  <= dout_d;
    end
  end

  assign OUT_ready      = ready_q;
  assign OUT_valid      = valid_q;
  assign OUT_count      = count_q;
  assign OUT_almostFull = af_q;
  // Fall-through output is forced to zero while empty so reset presents 0.
  assign OUT_data       = REG_MODE ? dout_q : (valid_q ? mem_rdata : '0);

endmodule

// File: tb/tb_fifo_flow.sv
// tb_fifo_flow: four fifo_flow instances (NUM=4 and NUM=3, both output modes)
// share one stimulus stream; each is checked every cycle against a queue model.
module tb_fifo_flow;

  localparam int N_DUT = 4;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic in_valid;
  logic in_ready;
  logic [7:0] in_data;

  logic [N_DUT-1:0]      o_ready;
  logic [N_DUT-1:0]      o_valid;
  logic [N_DUT-1:0]      o_af;
  logic [N_DUT-1:0][7:0] o_data;
  logic [2:0]            c0, c1;
  logic [1:0]            c2, c3;

  int vectors = 0;
  int errors  = 0;

  logic [7:0] mq [N_DUT][$];
  bit         jr [N_DUT];
  int         cmp_sz;

  always #5 clk = ~clk;

  fifo_flow #(.NUM(4), .WIDTH(8), .AF_THRESH(3), .REG_OUT(0)) u_ft4 (
    .clk(clk), .rst(rst), .IN_flush(flush), .IN_valid(in_valid), .IN_data(in_data),
    .OUT_ready(o_ready[0]), .OUT_valid(o_valid[0]), .OUT_data(o_data[0]),
    .IN_ready(in_ready), .OUT_count(c0), .OUT_almostFull(o_af[0]));

  fifo_flow #(.NUM(4), .WIDTH(8), .AF_THRESH(3), .REG_OUT(1)) u_ro4 (
    .clk(clk), .rst(rst), .IN_flush(flush), .IN_valid(in_valid), .IN_data(in_data),
    .OUT_ready(o_ready[1]), .OUT_valid(o_valid[1]), .OUT_data(o_data[1]),
    .IN_ready(in_ready), .OUT_count(c1), .OUT_almostFull(o_af[1]));

  fifo_flow #(.NUM(3), .WIDTH(8), .AF_THRESH(2), .REG_OUT(0)) u_ft3 (
    .clk(clk), .rst(rst), .IN_flush(flush), .IN_valid(in_valid), .IN_data(in_data),
    .OUT_ready(o_ready[2]), .OUT_valid(o_valid[2]), .OUT_data(o_data[2]),
    .IN_ready(in_ready), .OUT_count(c2), .OUT_almostFull(o_af[2]));

  fifo_flow #(.NUM(3), .WIDTH(8), .AF_THRESH(2), .REG_OUT(1)) u_ro3 (
    .clk(clk), .rst(rst), .IN_flush(flush), .IN_valid(in_valid), .IN_data(in_data),
    .OUT_ready(o_ready[3]), .OUT_valid(o_valid[3]), .OUT_data(o_data[3]),
    .IN_ready(in_ready), .OUT_count(c3), .OUT_almostFull(o_af[3]));

  function automatic int cap_of(input int i);
    return (i < 2) ? 4 : 3;
  endfunction

  function automatic int thr_of(input int i);
    return (i < 2) ? 3 : 2;
  endfunction

  function automatic logic [31:0] cnt_of(input int i);
    case (i)
      0:       return 32'(c0);
      1:       return 32'(c1);
      2:       return 32'(c2);
      default: return 32'(c3);
    endcase
  endfunction

  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h, expected %0h (t=%0t)", nm, idx, act, exp, $time);
    end
  endtask

  // Behavioural model: a bounded queue per instance.
  always @(posedge clk) begin
    for (int i = 0; i < N_DUT; i++) begin
      if (rst) begin
        mq[i].delete();
        jr[i] = 1'b1;
      end else if (flush) begin
        mq[i].delete();
        jr[i] = 1'b0;
      end else begin
        bit p, g;
        p = in_valid && (mq[i].size() < cap_of(i));
        g = in_ready && (mq[i].size() > 0);
        if (g) void'(mq[i].pop_front());
        if (p) begin
          mq[i].push_back(in_data);
          jr[i] = 1'b0;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    for (int i = 0; i < N_DUT; i++) begin
      cmp_sz = mq[i].size();
      check("valid", i, 32'(o_valid[i]), 32'(cmp_sz != 0));
      check("ready", i, 32'(o_ready[i]), 32'(cmp_sz != cap_of(i)));
      check("count", i, cnt_of(i), 32'(cmp_sz));
      check("almost_full", i, 32'(o_af[i]), 32'(cmp_sz >= thr_of(i)));
      if (cmp_sz != 0)
        check("data", i, 32'(o_data[i]), 32'(mq[i][0]));
      else if (jr[i])
        check("data_reset", i, 32'(o_data[i]), 32'd0);
    end
  end

  task automatic cyc(input bit r_, input bit f_, input bit v_, input logic [7:0] d_, input bit rd_);
    rst = r_; flush = f_; in_valid = v_; in_data = d_; in_ready = rd_;
    @(negedge clk);
  endtask

  // Hand-computed expectations for the NUM=4 instances.
  task automatic expect4(input string nm, input int cnt, input bit v, input bit rdy, input bit af);
    for (int i = 0; i < 2; i++) begin
      check({nm, ".count"}, i, cnt_of(i), 32'(cnt));
      check({nm, ".valid"}, i, 32'(o_valid[i]), 32'(v));
      check({nm, ".ready"}, i, 32'(o_ready[i]), 32'(rdy));
      check({nm, ".af"}, i, 32'(o_af[i]), 32'(af));
    end
  endtask

  task automatic expect_data4(input string nm, input logic [7:0] d);
    for (int i = 0; i < 2; i++) check({nm, ".data"}, i, 32'(o_data[i]), 32'(d));
  endtask

  initial begin
    logic [7:0] v8;
    bit r_, f_, v_, rd_;

    // Reset
    cyc(1, 0, 0, 8'h00, 0);
    cyc(1, 0, 0, 8'h00, 0);
    expect4("reset", 0, 0, 1, 0);
    expect_data4("reset", 8'h00);

    // Fill / drain
    cyc(0, 0, 1, 8'h11, 0); expect4("fill1", 1, 1, 1, 0); expect_data4("fill1", 8'h11);
    cyc(0, 0, 1, 8'h22, 0); expect4("fill2", 2, 1, 1, 0);
    cyc(0, 0, 1, 8'h33, 0); expect4("fill3", 3, 1, 1, 1);
    cyc(0, 0, 1, 8'h44, 0); expect4("fill4", 4, 1, 0, 1);
    cyc(0, 0, 1, 8'h55, 0); expect4("fill5", 4, 1, 0, 1);
    for (int k = 1; k <= 4; k++) begin
      v8 = 8'(8'h11 * k);
      expect_data4("drain", v8);
      cyc(0, 0, 0, 8'h00, 1);
    end
    expect4("drained", 0, 0, 1, 0);

    // Full with simultaneous pop and offered data
    for (int k = 1; k <= 4; k++) cyc(0, 0, 1, 8'(8'h11 * k), 0);
    cyc(0, 0, 1, 8'h55, 1);
    expect4("fullpop", 3, 1, 1, 1);
    for (int k = 2; k <= 4; k++) begin
      v8 = 8'(8'h11 * k);
      expect_data4("fullpop_drain", v8);
      cyc(0, 0, 0, 8'h00, 1);
    end
    expect4("fullpop_empty", 0, 0, 1, 0);

    // Wrap: steady push/pop at count 1
    cyc(0, 0, 1, 8'h00, 0);
    for (int k = 1; k <= 9; k++) cyc(0, 0, 1, 8'(k), 1);
    expect4("wrap", 1, 1, 1, 0);
    expect_data4("wrap", 8'h09);
    cyc(0, 0, 0, 8'h00, 1);

    // Empty fall-through latency and push+pop at count 1
    cyc(0, 0, 1, 8'hA5, 0); expect4("ft", 1, 1, 1, 0); expect_data4("ft", 8'hA5);
    cyc(0, 0, 1, 8'h5A, 1); expect4("ft_pp", 1, 1, 1, 0); expect_data4("ft_pp", 8'h5A);
    cyc(0, 0, 0, 8'h00, 1);

    // Flush with concurrent push/pop
    for (int k = 1; k <= 3; k++) cyc(0, 0, 1, 8'(8'h60 + k), 0);
    cyc(0, 1, 1, 8'h66, 1);
    expect4("flush", 0, 0, 1, 0);
    cyc(0, 0, 1, 8'h77, 0); expect4("post_flush", 1, 1, 1, 0); expect_data4("post_flush", 8'h77);

    // Reset mid-stream, together with flush and a push
    cyc(0, 0, 1, 8'h88, 0);
    cyc(1, 1, 1, 8'h99, 1);
    expect4("mid_reset", 0, 0, 1, 0);
    expect_data4("mid_reset", 8'h00);
    cyc(0, 0, 1, 8'h3C, 0); expect4("post_reset", 1, 1, 1, 0); expect_data4("post_reset", 8'h3C);
    cyc(0, 0, 0, 8'h00, 1);

    // Randomised traffic with alternating fill-biased and drain-biased phases
    for (int k = 0; k < 3000; k++) begin
      r_  = ($urandom_range(0, 99) == 0);
      f_  = ($urandom_range(0, 39) == 0);
      if (((k / 150) % 2) == 0) begin
        v_  = ($urandom_range(0, 3) != 0);
        rd_ = ($urandom_range(0, 2) == 0);
      end else begin
        v_  = ($urandom_range(0, 2) == 0);
        rd_ = ($urandom_range(0, 3) != 0);
      end
      v8 = 8'($urandom);
      cyc(r_, f_, v_, v8, rd_);
    end

    cyc(0, 0, 0, 8'h00, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
